security_zone_ctrl: RTL and testbench

- Parametrised multi-zone intrusion alarm controller; successor to the single-code, three-sensor alarm FSM.
- Adds:
  - N sensor zones with arming-time bypass.
  - Instant zones that skip the entry delay.
  - Exit delay and a tamper input.
  - Siren timeout.
  - Wrong-code lockout.
- Sits between the keypad decoder (strobed code words) and the siren/LED drivers.

---
 rtl/security_pkg.sv | 39 +++
 rtl/sec_delay_timer.sv | 34 +++
 rtl/security_zone_ctrl.sv | 142 ++++++++++++++
 tb/tb_security_zone_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/security_pkg.sv
// ---------------------------------------------------------------------------
// security_pkg : shared state encoding, timing defaults and sizing helpers
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package security_pkg;

    typedef enum logic [2:0] {
        DISARMED    = 3'd0,
        EXIT_DELAY  = 3'd1,
        ARMED       = 3'd2,
        ENTRY_DELAY = 3'd3,
        ALARM       = 3'd4,
        ALARM_HOLD  = 3'd5
    } sec_state_t;

    localparam longint unsigned CLK_HZ          = 64'd100_000_000;
    localparam longint unsigned DEF_EXIT_CYC    = 64'd3_000_000_000;
    localparam longint unsigned DEF_ENTRY_CYC   = 64'd3_000_000_000;
    localparam longint unsigned DEF_SIREN_CYC   = 64'd18_000_000_000;
    localparam longint unsigned DEF_LOCKOUT_CYC = 64'd6_000_000_000;

    // Counter width able to reach n-1; never narrower than one bit.
    function automatic int cyc_width(input longint unsigned n);
        return (n < 64'd2) ? 1 : $clog2(n);
    endfunction

    function automatic longint unsigned max3(input longint unsigned a,
                                             input longint unsigned b,
                                             input longint unsigned c);
        longint unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sec_delay_timer.sv
// ---------------------------------------------------------------------------
// sec_delay_timer : clearable up-counter with terminal-count flag
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sec_delay_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         enable,
    input  logic [W-1:0] terminal,
    output logic         done
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + W'(1);
        end
    end

    assign done = enable && (count == terminal);

endmodule

`default_nettype wire

// File: rtl/security_zone_ctrl.sv
// ---------------------------------------------------------------------------
// security_zone_ctrl : multi-zone intrusion alarm with delays, tamper, lockout
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module security_zone_ctrl
    import security_pkg::*;
#(
    parameter int                    NUM_ZONES    = 4,
    parameter int                    CODE_W       = 4,
    parameter logic [CODE_W-1:0]     PASSCODE     = 4'hC,
    parameter logic [NUM_ZONES-1:0]  INSTANT_MASK = 4'b0001,
    parameter longint unsigned       EXIT_CYC     = DEF_EXIT_CYC,
    parameter longint unsigned       ENTRY_CYC    = DEF_ENTRY_CYC,
    parameter longint unsigned       SIREN_CYC    = DEF_SIREN_CYC,
    parameter int                    MAX_TRIES    = 3,
    parameter longint unsigned       LOCKOUT_CYC  = DEF_LOCKOUT_CYC
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_ZONES-1:0]          sensors,
    input  logic [NUM_ZONES-1:0]          zone_bypass,
    input  logic                          tamper,
    input  logic [CODE_W-1:0]             code,
    input  logic                          code_valid,
    output logic                          alarm_siren,
    output logic                          armed,
    output logic [2:0]                    state_o,
    output logic [NUM_ZONES-1:0]          trip_zone,
    output logic [$clog2(MAX_TRIES+1)-1:0] fail_cnt,
    output logic                          locked
);

    localparam int TW = cyc_width(max3(EXIT_CYC, ENTRY_CYC, SIREN_CYC));
    localparam int LW = cyc_width(LOCKOUT_CYC);
    localparam int FW = $clog2(MAX_TRIES + 1);

    sec_state_t           state, nxt;
    logic [NUM_ZONES-1:0] bypass_latch, live;
    logic                 match, wrong, lock_hit;
    logic                 timed, expired, restart, lock_done;
    logic [TW-1:0]        term;

    always_comb begin
        // Tamper suppresses the correct code entirely while it is held.
        match    = code_valid & ~locked & ~tamper & (code == PASSCODE);
        wrong    = code_valid & ~locked & (code != PASSCODE);
        live     = sensors & ~bypass_latch;
        lock_hit = wrong && (fail_cnt == FW'(MAX_TRIES - 1));

        timed = 1'b0;
        term  = '0;
        case (state)
            EXIT_DELAY:  begin timed = 1'b1; term = TW'(EXIT_CYC - 1);  end
            ENTRY_DELAY: begin timed = 1'b1; term = TW'(ENTRY_CYC - 1); end
            ALARM:       begin timed = 1'b1; term = TW'(SIREN_CYC - 1); end
            default:     begin timed = 1'b0; term = '0;                 end
        endcase

        nxt = state;
        if (tamper) begin
            nxt = ALARM;
        end else if (match) begin
            nxt = (state == DISARMED) ? EXIT_DELAY : DISARMED;
        end else if (lock_hit && (state == ARMED || state == ENTRY_DELAY)) begin
            nxt = ALARM;
        end else begin
            case (state)
                EXIT_DELAY:  if (expired) nxt = (live == '0) ? ARMED : ENTRY_DELAY;
                ARMED: begin
                    if ((live & INSTANT_MASK) != '0) nxt = ALARM;
                    else if (live != '0)             nxt = ENTRY_DELAY;
                end
                ENTRY_DELAY: if (expired) nxt = ALARM;
                ALARM:       if (expired) nxt = ALARM_HOLD;
                ALARM_HOLD:  if ((live & ~trip_zone) != '0) nxt = ALARM;
                default:     nxt = state;
            endcase
        end

        // An expiry that keeps the state (tamper held in ALARM) rearms the timer.
        restart = (nxt != state) | expired;
    end

    sec_delay_timer #(.W(TW)) u_state_timer (
        .clk      (clk),
        .rst      (rst),
        .clear    (restart),
        .enable   (timed),
        .terminal (term),
        .done     (expired)
    );

    sec_delay_timer #(.W(LW)) u_lock_timer (
        .clk      (clk),
        .rst      (rst),
        .clear    (lock_hit),
        .enable   (locked),
        .terminal (LW'(LOCKOUT_CYC - 1)),
        .done     (lock_done)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= ARMED;
            armed        <= 1'b1;
            alarm_siren  <= 1'b0;
            trip_zone    <= '0;
            fail_cnt     <= '0;
            locked       <= 1'b0;
            bypass_latch <= '0;
        end else begin
            state       <= nxt;
            armed       <= (nxt == ARMED) || (nxt == ENTRY_DELAY) ||
                           (nxt == ALARM) || (nxt == ALARM_HOLD);
            alarm_siren <= (nxt == ALARM);

            if (state == DISARMED && match) bypass_latch <= zone_bypass;

            if (nxt == DISARMED)
                trip_zone <= '0;
            else if (tamper && state != ALARM)
                trip_zone <= '0;
            else if (state == ARMED && nxt != ARMED)
                trip_zone <= live;
            else if (state == ALARM_HOLD && nxt == ALARM)
                trip_zone <= trip_zone | live;

            if (match || lock_hit) fail_cnt <= '0;
            else if (wrong)        fail_cnt <= fail_cnt + FW'(1);

            if (lock_hit)       locked <= 1'b1;
            else if (lock_done) locked <= 1'b0;
        end
    end

    assign state_o = state;

endmodule

`default_nettype wire

// File: tb/tb_security_zone_ctrl.sv
// ---------------------------------------------------------------------------
// tb_security_zone_ctrl : directed scenarios checked against a countdown model
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_security_zone_ctrl;

    localparam int S_DIS = 0, S_EXIT = 1, S_ARM = 2, S_ENTRY = 3, S_ALARM = 4, S_HOLD = 5;
    localparam int EXIT_N = 8, ENTRY_N = 10, SIREN_N = 20, TRIES = 3, LOCK_N = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] sensors = '0, zone_bypass = '0, code = '0;
    logic       tamper = 1'b0, code_valid = 1'b0;
    logic       alarm_siren, armed, locked;
    logic [2:0] state_o;
    logic [3:0] trip_zone;
    logic [1:0] fail_cnt;

    int checks = 0, failures = 0;

    security_zone_ctrl #(
        .NUM_ZONES(4), .CODE_W(4), .PASSCODE(4'hC), .INSTANT_MASK(4'b0001),
        .EXIT_CYC(64'd8), .ENTRY_CYC(64'd10), .SIREN_CYC(64'd20),
        .MAX_TRIES(3), .LOCKOUT_CYC(64'd16)
    ) dut (
        .clk(clk), .rst(rst), .sensors(sensors), .zone_bypass(zone_bypass),
        .tamper(tamper), .code(code), .code_valid(code_valid),
        .alarm_siren(alarm_siren), .armed(armed), .state_o(state_o),
        .trip_zone(trip_zone), .fail_cnt(fail_cnt), .locked(locked)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Model: remaining-cycle countdowns instead of up-counters.
    int   m_st = S_ARM, m_rem = 0, m_fail = 0, m_lock_left = 0, ns;
    logic [3:0] m_trip = '0, m_byp = '0, lv;
    logic m_valid = 1'b0, mm, mw, lock_hit, expired, locked_now;

    function automatic int dur(input int s);
        case (s)
            S_EXIT:  return EXIT_N;
            S_ENTRY: return ENTRY_N;
            S_ALARM: return SIREN_N;
            default: return 0;
        endcase
    endfunction

    always @(posedge clk) begin
        if (!rst) begin
            m_st = S_ARM; m_rem = 0; m_fail = 0; m_lock_left = 0;
            m_trip = '0; m_byp = '0; m_valid = 1'b1;
        end else begin
            locked_now = (m_lock_left != 0);
            mm = code_valid && !locked_now && !tamper && (code == 4'hC);
            mw = code_valid && !locked_now && (code != 4'hC);
            lv = sensors & ~m_byp;
            lock_hit = mw && (m_fail + 1 == TRIES);
            expired = (dur(m_st) != 0) && (m_rem == 1);
            ns = m_st;
            if (tamper) ns = S_ALARM;
            else if (mm) ns = (m_st == S_DIS) ? S_EXIT : S_DIS;
            else if (lock_hit && (m_st == S_ARM || m_st == S_ENTRY)) ns = S_ALARM;
            else if (m_st == S_EXIT && expired) ns = (lv == 0) ? S_ARM : S_ENTRY;
            else if (m_st == S_ARM && lv[0]) ns = S_ALARM;
            else if (m_st == S_ARM && lv != 0) ns = S_ENTRY;
            else if (m_st == S_ENTRY && expired) ns = S_ALARM;
            else if (m_st == S_ALARM && expired) ns = S_HOLD;
            else if (m_st == S_HOLD && (lv & ~m_trip) != 0) ns = S_ALARM;

            if (ns == S_DIS) m_trip = '0;
            else if (tamper && m_st != S_ALARM) m_trip = '0;
            else if (m_st == S_ARM && ns != S_ARM) m_trip = lv;
            else if (m_st == S_HOLD && ns == S_ALARM) m_trip = m_trip | lv;

            if (m_lock_left > 0) m_lock_left--;
            if (mm) m_fail = 0;
            else if (lock_hit) begin m_fail = 0; m_lock_left = LOCK_N; end
            else if (mw) m_fail++;

            if (ns != m_st || expired) m_rem = dur(ns);
            else if (dur(m_st) != 0) m_rem--;

            if (m_st == S_DIS && mm) m_byp = zone_bypass;
            m_st = ns;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("cmp_state", state_o, m_st);
            check("cmp_armed", armed, (m_st >= S_ARM) ? 1 : 0);
            check("cmp_siren", alarm_siren, (m_st == S_ALARM) ? 1 : 0);
            check("cmp_trip", trip_zone, m_trip);
            check("cmp_fail", fail_cnt, m_fail);
            check("cmp_locked", locked, (m_lock_left != 0) ? 1 : 0);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic pulse(input logic [3:0] c);
        code = c; code_valid = 1'b1;
        tick(1);
        code_valid = 1'b0;
    endtask

    // Edges until state_o reaches target; a timeout returns the bound.
    task automatic wait_state(input int target, output int n);
        n = 0;
        while (state_o != 3'(target) && n < 100) begin tick(1); n++; end
    endtask

    int n;

    initial begin
        tick(2);
        rst = 1'b1;
        check("reset_state", state_o, S_ARM);
        check("reset_armed", armed, 1);
        check("reset_siren", alarm_siren, 0);
        check("reset_fail", fail_cnt, 0);

        // Delayed zone: entry delay then siren then hold
        sensors = 4'b0100; tick(1);
        check("s1_entry", state_o, S_ENTRY);
        check("s1_trip", trip_zone, 4'b0100);
        wait_state(S_ALARM, n);  check("s1_entry_len", n, 10);
        check("s1_siren_on", alarm_siren, 1);
        wait_state(S_HOLD, n);   check("s1_siren_len", n, 20);
        check("s1_siren_off", alarm_siren, 0);
        tick(3); check("s1_hold_stays", state_o, S_HOLD);
        sensors = 4'b0000;
        pulse(4'hC); check("s1_disarm", state_o, S_DIS);
        pulse(4'hC); wait_state(S_ARM, n); check("s1_rearm_len", n, 8);

        // Instant zone
        sensors = 4'b0001; tick(1);
        check("s2_instant", state_o, S_ALARM);
        sensors = 4'b0000;
        pulse(4'hC);
        check("s2_disarm", state_o, S_DIS);
        check("s2_trip_clr", trip_zone, 0);

        // Bypassed zone
        zone_bypass = 4'b0010;
        pulse(4'hC); check("s3_exit", state_o, S_EXIT);
        zone_bypass = 4'b0000;
        wait_state(S_ARM, n); check("s3_exit_len", n, 8);
        sensors = 4'b0010; tick(3);
        check("s3_bypassed", state_o, S_ARM);
        sensors = 4'b0000;

        // Wrong-code lockout
        pulse(4'h3); check("s4_fail1", fail_cnt, 1);
        pulse(4'h3); check("s4_fail2", fail_cnt, 2);
        pulse(4'h3);
        check("s4_alarm", state_o, S_ALARM);
        check("s4_locked", locked, 1);
        check("s4_fail_clr", fail_cnt, 0);
        pulse(4'hC); check("s4_ignored", state_o, S_ALARM);
        tick(14);    check("s4_still_locked", locked, 1);
        tick(1);     check("s4_unlocked", locked, 0);
        pulse(4'hC); check("s4_disarm", state_o, S_DIS);

        // Tamper overrides everything
        tamper = 1'b1; tick(1);
        check("s5_tamper", state_o, S_ALARM);
        check("s5_trip_zero", trip_zone, 0);
        pulse(4'hC); check("s5_code_ignored", state_o, S_ALARM);
        tamper = 1'b0; tick(1);
        pulse(4'hC); check("s5_disarm", state_o, S_DIS);

        // Mid-delay reset
        pulse(4'hC); wait_state(S_ARM, n);
        sensors = 4'b0100; tick(1);
        check("s6_entry", state_o, S_ENTRY);
        tick(5);
        rst = 1'b0; tick(1); rst = 1'b1;
        check("s6_reset_state", state_o, S_ARM);
        check("s6_reset_siren", alarm_siren, 0);
        check("s6_reset_fail", fail_cnt, 0);
        tick(1); check("s6_reentry", state_o, S_ENTRY);
        wait_state(S_ALARM, n); check("s6_timer_restart", n, 10);
        sensors = 4'b0000;

        // Code and instant trip on the same edge: code wins
        pulse(4'hC); pulse(4'hC); wait_state(S_ARM, n);
        sensors = 4'b0001; pulse(4'hC);
        check("s7_code_wins", state_o, S_DIS);
        sensors = 4'b0000; tick(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
